// File: rtl/pdm_audio_dac4.sv
// pdm_audio_dac4: boxcar moving-average decimator that turns the 1-bit PDM
// audio stream from the TT flame core into a DAC_W-bit level for the ULX3S
// resistor DAC. A running popcount of the last 2^WIN_LOG2 samples (stage 1) is
// requantised to DAC_W bits and registered one cycle later (stage 2).
module pdm_audio_dac4 #(
  parameter int WIN_LOG2   = 6,
  parameter int DAC_W      = 4,
  parameter int SAMPLE_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              pdm_in,
  input  logic              mute,
  output logic [DAC_W-1:0]  dac_out,
  output logic              dac_stb,
  output logic [WIN_LOG2:0] level
);

  localparam int WIN_LEN = 1 << WIN_LOG2;
  // A one-bit counter is kept even when SAMPLE_DIV=1 so the vector is never zero width.
  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [DAC_W-1:0] MIDSCALE = {1'b1, {(DAC_W-1){1'b0}}};

  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                tick;
  logic [WIN_LEN-1:0]  win_reg;
  logic                oldest;
  logic [WIN_LOG2:0]   sum_reg, sum_next;
  logic                upd_reg;
  logic [DAC_W-1:0]    q;
  logic [DAC_W-1:0]    dac_reg;
  logic                stb_reg;

  assign tick   = ena && (cnt_reg == CNT_LAST);
  assign oldest = win_reg[WIN_LEN-1];

  // Next divider count: advance only while enabled, wrap on the sample tick.
  always_comb begin
    cnt_next = cnt_reg;
    if (ena) begin
      cnt_next = tick ? '0 : cnt_reg + 1'b1;
    end
  end

  // Running sum update: incoming and departing bits cancel when equal, so the
  // sum always equals the popcount of the window and cannot wrap.
  always_comb begin
    sum_next = sum_reg + {{WIN_LOG2{1'b0}}, pdm_in} - {{WIN_LOG2{1'b0}}, oldest};
  end

  // Requantise: a completely full window (sum = 2^WIN_LOG2) saturates to full scale.
  always_comb begin
    q = sum_reg[WIN_LOG2] ? {DAC_W{1'b1}} : sum_reg[WIN_LOG2-1 -: DAC_W];
  end

  // Sample divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Stage 1: window shift register and running sum, advanced on each sample tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_reg <= '0;
      sum_reg <= '0;
      upd_reg <= 1'b0;
    end else begin
      upd_reg <= tick;
      if (tick) begin
        win_reg <= {win_reg[WIN_LEN-2:0], pdm_in};
        sum_reg <= sum_next;
      end
    end
  end

  // Stage 2: register the DAC level one cycle after each sum update. This is
  // deliberately not gated by ena so an update already in flight completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_reg <= '0;
      stb_reg <= 1'b0;
    end else begin
      stb_reg <= upd_reg;
      if (upd_reg) begin
        dac_reg <= mute ? MIDSCALE : q;
      end
    end
  end

  assign dac_out = dac_reg;
  assign dac_stb = stb_reg;
  assign level   = sum_reg;

endmodule

// File: tb/tb_pdm_audio_dac4.sv
// tb_pdm_audio_dac4: directed checks of the PDM boxcar DAC. Instance dut runs
// with a sample tick every cycle; instance dut4 ticks every 4th cycle.
module tb_pdm_audio_dac4;

  logic       clk;
  logic       rst_n, ena, pdm_in, mute;
  logic [3:0] dac_out;
  logic       dac_stb;
  logic [6:0] level;

  logic       rst4_n, ena4, pdm4, mute4;
  logic [3:0] dac4;
  logic       stb4;
  logic [6:0] level4;

  int total;
  int bad;

  pdm_audio_dac4 #(.WIN_LOG2(6), .DAC_W(4), .SAMPLE_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pdm_in(pdm_in), .mute(mute),
    .dac_out(dac_out), .dac_stb(dac_stb), .level(level)
  );

  pdm_audio_dac4 #(.WIN_LOG2(6), .DAC_W(4), .SAMPLE_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .ena(ena4), .pdm_in(pdm4), .mute(mute4),
    .dac_out(dac4), .dac_stb(stb4), .level(level4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected 4-bit DAC level for a window popcount m (hand rule: m/4, 64 -> 15).
  function automatic logic [3:0] qexp(input int m);
    if (m >= 64) return 4'd15;
    return 4'(m / 4);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; pdm_in = 1'b1; mute = 1'b0;
    rst4_n = 1'b0; ena4 = 1'b1; pdm4 = 1'b1; mute4 = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (level !== 7'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (dac_out !== 4'd0) begin bad++; $display("FAIL reset_dac got=%0d exp=0", dac_out); end
    total++; if (dac_stb !== 1'b0) begin bad++; $display("FAIL reset_stb got=%0d exp=0", dac_stb); end
    total++; if (level4 !== 7'd0) begin bad++; $display("FAIL reset_level4 got=%0d exp=0", level4); end
    total++; if (dac4 !== 4'd0) begin bad++; $display("FAIL reset_dac4 got=%0d exp=0", dac4); end
    total++; if (stb4 !== 1'b0) begin bad++; $display("FAIL reset_stb4 got=%0d exp=0", stb4); end
    $display("reset: level=%0d dac=%0d stb=%0d", level, dac_out, dac_stb);
  endtask

  // Called at a negedge with reset just released: constant ones fill the window.
  task automatic test_ramp(input string tag);
    int exp_lv;
    rst_n = 1'b1; pdm_in = 1'b1; mute = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      exp_lv = (k > 64) ? 64 : k;
      total++;
      if (level !== 7'(exp_lv)) begin
        bad++; $display("FAIL %s_level k=%0d got=%0d exp=%0d", tag, k, level, exp_lv);
      end
      if (k == 1) begin
        total++;
        if (dac_stb !== 1'b0 || dac_out !== 4'd0) begin
          bad++; $display("FAIL %s_first stb=%0d dac=%0d exp stb=0 dac=0", tag, dac_stb, dac_out);
        end
      end else begin
        total++;
        if (dac_stb !== 1'b1 || dac_out !== qexp(k - 1)) begin
          bad++; $display("FAIL %s_dac k=%0d stb=%0d got=%0d exp=%0d", tag, k, dac_stb, dac_out, qexp(k - 1));
        end
      end
    end
    $display("%s: level=%0d dac=%0d", tag, level, dac_out);
  endtask

  task automatic test_half_duty();
    for (int i = 0; i < 140; i++) begin
      pdm_in = (i % 2 == 0);
      @(negedge clk);
      if (i >= 130) begin
        total++;
        if (level !== 7'd32) begin bad++; $display("FAIL half_level i=%0d got=%0d exp=32", i, level); end
        total++;
        if (dac_out !== 4'd8) begin bad++; $display("FAIL half_dac i=%0d got=%0d exp=8", i, dac_out); end
      end
    end
    $display("half_duty: level=%0d dac=%0d", level, dac_out);
  endtask

  task automatic test_mute();
    pdm_in = 1'b1;
    repeat (70) @(negedge clk);
    total++; if (dac_out !== 4'd15) begin bad++; $display("FAIL mute_pre got=%0d exp=15", dac_out); end
    mute = 1'b1;
    @(negedge clk);
    total++; if (dac_out !== 4'd8) begin bad++; $display("FAIL mute_on got=%0d exp=8", dac_out); end
    total++; if (dac_stb !== 1'b1) begin bad++; $display("FAIL mute_stb got=%0d exp=1", dac_stb); end
    total++; if (level !== 7'd64) begin bad++; $display("FAIL mute_level got=%0d exp=64", level); end
    mute = 1'b0;
    @(negedge clk);
    total++; if (dac_out !== 4'd15) begin bad++; $display("FAIL mute_off got=%0d exp=15", dac_out); end
    $display("mute: dac=%0d level=%0d", dac_out, level);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (dac_stb !== 1'b1 || dac_out !== 4'd15) begin
        bad++; $display("FAIL b2b i=%0d stb=%0d dac=%0d exp stb=1 dac=15", i, dac_stb, dac_out);
      end
    end
    $display("back_to_back: 20 strobes checked");
  endtask

  // Checks dut4 after active edge e (ticks land on edges 4,8,...).
  task automatic chk_div(input int e);
    logic exp_stb;
    exp_stb = (e >= 5) && ((e - 1) % 4 == 0);
    total++;
    if (level4 !== 7'(e / 4)) begin bad++; $display("FAIL div_level e=%0d got=%0d exp=%0d", e, level4, e / 4); end
    total++;
    if (stb4 !== exp_stb) begin bad++; $display("FAIL div_stb e=%0d got=%0d exp=%0d", e, stb4, exp_stb); end
    total++;
    if (dac4 !== qexp((e - 1) / 4)) begin bad++; $display("FAIL div_dac e=%0d got=%0d exp=%0d", e, dac4, qexp((e - 1) / 4)); end
  endtask

  task automatic test_divider_ena();
    rst4_n = 1'b1; ena4 = 1'b1; pdm4 = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      @(negedge clk);
      chk_div(e);
    end
    ena4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (stb4 !== 1'b0 || level4 !== 7'd5 || dac4 !== 4'd1) begin
        bad++; $display("FAIL div_frozen i=%0d stb=%0d level=%0d dac=%0d exp 0/5/1", i, stb4, level4, dac4);
      end
    end
    ena4 = 1'b1;
    for (int e = 23; e <= 36; e++) begin
      @(negedge clk);
      chk_div(e);
    end
    // Edge 36 was a tick: the stage-2 update still completes with ena low.
    ena4 = 1'b0;
    @(negedge clk);
    total++;
    if (stb4 !== 1'b1 || dac4 !== 4'd2 || level4 !== 7'd9) begin
      bad++; $display("FAIL div_inflight stb=%0d dac=%0d level=%0d exp 1/2/9", stb4, dac4, level4);
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if (stb4 !== 1'b0 || level4 !== 7'd9) begin
        bad++; $display("FAIL div_after stb=%0d level=%0d exp 0/9", stb4, level4);
      end
    end
    $display("divider: level=%0d dac=%0d", level4, dac4);
  endtask

  task automatic test_reset_midop();
    total++; if (level !== 7'd64) begin bad++; $display("FAIL midop_pre got=%0d exp=64", level); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (level !== 7'd0) begin bad++; $display("FAIL midop_level got=%0d exp=0", level); end
    total++; if (dac_out !== 4'd0) begin bad++; $display("FAIL midop_dac got=%0d exp=0", dac_out); end
    total++; if (dac_stb !== 1'b0) begin bad++; $display("FAIL midop_stb got=%0d exp=0", dac_stb); end
    @(negedge clk);
    $display("reset_midop: level=%0d dac=%0d", level, dac_out);
    test_ramp("ramp2");
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_ramp("ramp");
    test_half_duty();
    test_mute();
    test_back_to_back();
    test_divider_ena();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
